// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, a clog2 helper and the
// default baud constants used by uart_tx.
package uart_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACCEPT  = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;

  localparam int unsigned UART_CLK_HZ       = 50_000_000;
  localparam int unsigned UART_BAUD         = 115_200;
  localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i,
// searching upward modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] winner_o,
  output logic           any_o
);

  localparam int SW = IDW + 1;

  logic [SW-1:0]  sum;
  logic [IDW-1:0] idx;

  // Walk from the farthest candidate back toward ptr so the nearest valid wins.
  always_comb begin
    winner_o = '0;
    sum      = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[IDW-1:0];
      if (valid_i[idx]) winner_o = idx;
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N byte streams; the grant is held for a whole
// message (until a byte flagged last) so lines from different sources never mix.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N            = 4,
  parameter int IDW          = clog2(N),
  parameter int LOCK_TIMEOUT = 65535,
  parameter int TOW          = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [IDW-1:0] grant_id,
  output logic           grant_active,
  output logic           lock_timeout,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy
);

  logic [2:0]     state_q, state_d;
  logic [IDW-1:0] grantId_q, grantId_d;
  logic           grantActive_q, grantActive_d;
  logic           lockTimeout_q, lockTimeout_d;
  logic [7:0]     txData_q, txData_d;
  logic           last_q, last_d;
  logic [IDW-1:0] rrPtr_q, rrPtr_d;
  logic [TOW-1:0] toCnt_q, toCnt_d;

  logic [IDW-1:0] pickWinner;
  logic           pickAny;
  logic [IDW-1:0] ptrNext;
  logic [TOW-1:0] cntInc;
  logic           timeoutHit;
  logic [7:0]     reqByte [N];

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .valid_i  (req_valid),
    .ptr_i    (rrPtr_q),
    .winner_o (pickWinner),
    .any_o    (pickAny)
  );

  always_comb begin
    for (int i = 0; i < N; i++) reqByte[i] = req_data[8*i +: 8];
  end

  // Modulo-N increment works for non-power-of-two N; the counter saturates.
  assign ptrNext    = (grantId_q == IDW'(N - 1)) ? '0 : grantId_q + 1'b1;
  assign cntInc     = (&toCnt_q) ? toCnt_q : toCnt_q + 1'b1;
  assign timeoutHit = (LOCK_TIMEOUT != 0) && (cntInc == TOW'(LOCK_TIMEOUT));

  always_comb begin
    state_d       = state_q;
    grantId_d     = grantId_q;
    grantActive_d = grantActive_q;
    lockTimeout_d = 1'b0;
    txData_d      = txData_q;
    last_d        = last_q;
    rrPtr_d       = rrPtr_q;
    toCnt_d       = toCnt_q;
    case (state_q)
      // Busy may still be high after reset because uart_tx itself is never reset.
      IDLE: begin
        if (!tx_busy && pickAny) begin
          grantId_d     = pickWinner;
          grantActive_d = 1'b1;
          toCnt_d       = '0;
          state_d       = ACCEPT;
        end
      end
      ACCEPT: begin
        if (req_valid[grantId_q]) begin
          txData_d = reqByte[grantId_q];
          last_d   = req_last[grantId_q];
          toCnt_d  = '0;
          state_d  = START;
        end else begin
          toCnt_d = cntInc;
          if (timeoutHit) begin
            lockTimeout_d = 1'b1;
            grantActive_d = 1'b0;
            rrPtr_d       = ptrNext;
            toCnt_d       = '0;
            state_d       = IDLE;
          end
        end
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            grantActive_d = 1'b0;
            rrPtr_d       = ptrNext;
            state_d       = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grantId_q     <= '0;
      grantActive_q <= 1'b0;
      lockTimeout_q <= 1'b0;
      txData_q      <= '0;
      last_q        <= 1'b0;
      rrPtr_q       <= '0;
      toCnt_q       <= '0;
    end else begin
      state_q       <= state_d;
      grantId_q     <= grantId_d;
      grantActive_q <= grantActive_d;
      lockTimeout_q <= lockTimeout_d;
      txData_q      <= txData_d;
      last_q        <= last_d;
      rrPtr_q       <= rrPtr_d;
      toCnt_q       <= toCnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ACCEPT) req_ready[grantId_q] = 1'b1;
  end

  assign tx_start     = (state_q == START);
  assign tx_data      = txData_q;
  assign grant_id     = grantId_q;
  assign grant_active = grantActive_q;
  assign lock_timeout = lockTimeout_q;

endmodule
